// File: rtl/reflet_vga_txt_terminal_pkg.sv
// Shared definitions for the text terminal: font geometry, control codes,
// FSM state type and the printable-byte classifier.
package reflet_vga_txt_terminal_pkg;

    // Glyph cell size. The text block uses the same values.
    localparam int FONT_WIDTH  = 8;
    localparam int FONT_HEIGHT = 8;

    // Control codes that the terminal acts on. Every other code below 0x20,
    // and DEL, is accepted and ignored.
    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_CR  = 8'h0D;
    localparam logic [7:0] CC_DEL = 8'h7F;
    localparam logic [7:0] SPACE  = 8'h20;

    typedef enum logic [1:0] {
        ST_CLEAR      = 2'd0,
        ST_IDLE       = 2'd1,
        ST_CLEAR_LINE = 2'd2
    } term_state_e;

    // Printable means 0x20..0x7E plus the whole upper half 0x80..0xFF.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= SPACE) && (c != CC_DEL);
    endfunction

endpackage

// File: rtl/reflet_vga_txt_terminal_cursor.sv
// Column/row counter pair. Used twice by the terminal: once as the text
// cursor and once as the address generator for the clear sweeps.
module reflet_vga_txt_terminal_cursor #(
    parameter int COLS = 8,
    parameter int ROWS = 4,
    parameter int HW   = 3,
    parameter int VW   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          col_zero_i,
    input  logic          col_inc_i,
    input  logic          col_dec_i,
    input  logic          row_zero_i,
    input  logic          row_adv_i,
    output logic [HW-1:0] col_o,
    output logic [VW-1:0] row_o,
    output logic          col_last_o
);

    localparam logic [HW-1:0] COL_MAX = HW'(COLS - 1);
    localparam logic [VW-1:0] ROW_MAX = VW'(ROWS - 1);

    logic [HW-1:0] col_q, col_d;
    logic [VW-1:0] row_q, row_d;

    assign col_o      = col_q;
    assign row_o      = row_q;
    assign col_last_o = (col_q == COL_MAX);

    // Next position: zero beats increment beats decrement; both axes wrap by
    // explicit compare so non power-of-two sizes never leave the screen.
    always_comb begin
        col_d = col_q;
        if (col_zero_i) begin
            col_d = '0;
        end else if (col_inc_i) begin
            col_d = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
        end else if (col_dec_i && (col_q != '0)) begin
            col_d = col_q - 1'b1;
        end

        row_d = row_q;
        if (row_zero_i) begin
            row_d = '0;
        end else if (row_adv_i) begin
            row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
        end
    end

    // Position registers, cleared to the top-left corner on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/reflet_vga_txt_terminal.sv
// Byte-stream front end for the text-mode VGA block: turns characters and
// control codes into cell writes, tracks the cursor, wraps lines and runs the
// full-screen and single-line clear sweeps.
module reflet_vga_txt_terminal
    import reflet_vga_txt_terminal_pkg::*;
#(
    parameter int h_size        = 640,
    parameter int v_size        = 480,
    parameter int color_depth   = 8,
    parameter int bit_reduction = 0,
    localparam int COLS = (h_size / FONT_WIDTH) >> bit_reduction,
    localparam int ROWS = (v_size / FONT_HEIGHT) >> bit_reduction,
    localparam int HW   = $clog2(h_size / FONT_WIDTH) - bit_reduction,
    localparam int VW   = $clog2(v_size / FONT_HEIGHT) - bit_reduction
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   char_valid,
    output logic                   char_ready,
    input  logic [7:0]             char_data,
    input  logic [color_depth-1:0] R_fg_in,
    input  logic [color_depth-1:0] G_fg_in,
    input  logic [color_depth-1:0] B_fg_in,
    input  logic [color_depth-1:0] R_bg_in,
    input  logic [color_depth-1:0] G_bg_in,
    input  logic [color_depth-1:0] B_bg_in,
    output logic                   write_en,
    output logic [HW-1:0]          h_txt_out,
    output logic [VW-1:0]          v_txt_out,
    output logic [7:0]             char_out,
    output logic [color_depth-1:0] R_fg_out,
    output logic [color_depth-1:0] G_fg_out,
    output logic [color_depth-1:0] B_fg_out,
    output logic [color_depth-1:0] R_bg_out,
    output logic [color_depth-1:0] G_bg_out,
    output logic [color_depth-1:0] B_bg_out,
    output logic [HW-1:0]          cursor_h,
    output logic [VW-1:0]          cursor_v
);

    localparam int CW = 3 * color_depth;
    localparam logic [VW-1:0] ROW_MAX = VW'(ROWS - 1);

    term_state_e state_q;

    logic          writeEn_q;
    logic [HW-1:0] hTxt_q;
    logic [VW-1:0] vTxt_q;
    logic [7:0]    char_q;
    logic [CW-1:0] fgOut_q, bgOut_q;
    logic [CW-1:0] fgLat_q, bgLat_q;

    logic [CW-1:0] fgIn, bgIn;
    logic          accept, isPrint, lineAdv, startClear;

    logic [HW-1:0] curCol, swpCol;
    logic [VW-1:0] curRow, swpRow;
    logic          curColLast, swpColLast, swpRowLast;
    logic          curColZero, curColInc, curColDec, curRowZero, curRowAdv;
    logic          swpColZero, swpColInc, swpRowZero, swpRowAdv;

    assign fgIn = {R_fg_in, G_fg_in, B_fg_in};
    assign bgIn = {R_bg_in, G_bg_in, B_bg_in};
    assign {R_fg_out, G_fg_out, B_fg_out} = fgOut_q;
    assign {R_bg_out, G_bg_out, B_bg_out} = bgOut_q;

    assign write_en  = writeEn_q;
    assign h_txt_out = hTxt_q;
    assign v_txt_out = vTxt_q;
    assign char_out  = char_q;
    assign cursor_h  = curCol;
    assign cursor_v  = curRow;

    // Bytes are only taken while idle; the clear sweeps own the write port.
    assign char_ready = (state_q == ST_IDLE);
    assign accept     = char_valid && char_ready;
    assign isPrint    = is_printable(char_data);
    assign lineAdv    = accept && ((char_data == CC_LF) || (isPrint && curColLast));
    assign startClear = accept && (char_data == CC_FF);
    assign swpRowLast = (swpRow == ROW_MAX);

    // Text cursor.
    reflet_vga_txt_terminal_cursor #(
        .COLS(COLS), .ROWS(ROWS), .HW(HW), .VW(VW)
    ) u_cursor (
        .clk        (clk),
        .reset      (reset),
        .col_zero_i (curColZero),
        .col_inc_i  (curColInc),
        .col_dec_i  (curColDec),
        .row_zero_i (curRowZero),
        .row_adv_i  (curRowAdv),
        .col_o      (curCol),
        .row_o      (curRow),
        .col_last_o (curColLast)
    );

    // Clear-sweep address; it always parks at (0,0) between sweeps.
    reflet_vga_txt_terminal_cursor #(
        .COLS(COLS), .ROWS(ROWS), .HW(HW), .VW(VW)
    ) u_sweep (
        .clk        (clk),
        .reset      (reset),
        .col_zero_i (swpColZero),
        .col_inc_i  (swpColInc),
        .col_dec_i  (1'b0),
        .row_zero_i (swpRowZero),
        .row_adv_i  (swpRowAdv),
        .col_o      (swpCol),
        .row_o      (swpRow),
        .col_last_o (swpColLast)
    );

    // Decode the current state and accepted byte into counter controls.
    always_comb begin
        curColZero = 1'b0;
        curColInc  = 1'b0;
        curColDec  = 1'b0;
        curRowZero = 1'b0;
        curRowAdv  = 1'b0;
        swpColZero = 1'b0;
        swpColInc  = 1'b0;
        swpRowZero = 1'b0;
        swpRowAdv  = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                swpColInc = 1'b1;
                swpRowAdv = swpColLast;
            end
            ST_CLEAR_LINE: begin
                swpColInc = 1'b1;
            end
            ST_IDLE: begin
                if (accept) begin
                    if (lineAdv) begin
                        curColZero = 1'b1;
                        curRowAdv  = 1'b1;
                    end else if (isPrint) begin
                        curColInc = 1'b1;
                    end else if (char_data == CC_CR) begin
                        curColZero = 1'b1;
                    end else if (char_data == CC_BS) begin
                        curColDec = 1'b1;
                    end else if (startClear) begin
                        curColZero = 1'b1;
                        curRowZero = 1'b1;
                        swpColZero = 1'b1;
                        swpRowZero = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // FSM with registered write port: clear sweeps emit one space per cycle,
    // idle bytes are written one cycle after acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            writeEn_q <= 1'b0;
            hTxt_q    <= '0;
            vTxt_q    <= '0;
            char_q    <= '0;
            fgOut_q   <= '0;
            bgOut_q   <= '0;
            fgLat_q   <= '1;
            bgLat_q   <= '0;
        end else begin
            writeEn_q <= 1'b0;
            unique case (state_q)
                ST_CLEAR: begin
                    writeEn_q <= 1'b1;
                    hTxt_q    <= swpCol;
                    vTxt_q    <= swpRow;
                    char_q    <= SPACE;
                    fgOut_q   <= fgLat_q;
                    bgOut_q   <= bgLat_q;
                    if (swpColLast && swpRowLast) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CLEAR_LINE: begin
                    writeEn_q <= 1'b1;
                    hTxt_q    <= swpCol;
                    vTxt_q    <= curRow;
                    char_q    <= SPACE;
                    fgOut_q   <= fgLat_q;
                    bgOut_q   <= bgLat_q;
                    if (swpColLast) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        fgLat_q <= fgIn;
                        bgLat_q <= bgIn;
                        if (isPrint) begin
                            writeEn_q <= 1'b1;
                            hTxt_q    <= curCol;
                            vTxt_q    <= curRow;
                            char_q    <= char_data;
                            fgOut_q   <= fgIn;
                            bgOut_q   <= bgIn;
                        end
                        if (lineAdv) begin
                            state_q <= ST_CLEAR_LINE;
                        end else if (startClear) begin
                            state_q <= ST_CLEAR;
                        end
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

endmodule
